mean_filter_sched: RTL and testbench
====================================

# mean_filter_sched

Round-robin scheduler that shares one trimmed-mean filter between `N_CH` sample requesters. It grants the filter to one channel at a time and streams exactly `WIN` consecutive samples from that channel into it. It then collects the filter's single-cycle result and tags it with the channel index. It sits between the per-channel sample sources and the filter instance, and owns the filter's enable and data inputs.

## Interface
- `N_CH`, 4: number of requesting channels, 2..8.
- `WIN`, 11: samples per window; must match the filter's window length.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_i` in N_CH: channel c has a valid sample on its data slice this cycle.
- `data_i` in 8*N_CH: channel c sample at bits [8c+7:8c].
- `ack_o` out N_CH: sample of channel c consumed this cycle (combinational).
- `filt_en_o` out 1: filter enable (registered).
- `filt_data_o` out 8: filter sample (registered).
- `filt_data_i` in 8: filter result.
- `filt_done_i` in 1: filter result valid.
- `res_data_o` out 8: window result.
- `res_ch_o` out $clog2(N_CH): channel that produced `res_data_o`.
- `res_valid_o` out 1: one-cycle result strobe.
- `abort_o` out 1: one-cycle strobe; window abandoned by requester.
- `err_o` out 1: one-cycle strobe; filter did not signal done when expected.

## Operation
- States: IDLE, RUN, DRAIN, WAIT.
- IDLE:
  - `filt_en_o` = 0.
  - If any `req_i` bit is set, latch the winner into `gnt`, clear the sample counter, and go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - `ack_o[gnt] = req_i[gnt]`; all other `ack_o` bits are 0.
  - On ack: `filt_en_o <= 1`, `filt_data_o <= data_i[gnt]`, counter +1.
  - When the WIN-th sample is acked, go to DRAIN.
  - If `req_i[gnt]` = 0 with counter < WIN: `filt_en_o <= 0`, pulse `abort_o`, go to IDLE. No result is produced.
- DRAIN: `filt_en_o <= 0`; go to WAIT.
- WAIT:
  - If `filt_done_i` = 1, capture `filt_data_i` into `res_data_o` and `gnt` into `res_ch_o`, and pulse `res_valid_o`.
  - If `filt_done_i` = 0, pulse `err_o` instead.
  - Go to IDLE in either case.
- Invariant: `filt_en_o` is low for at least one cycle between windows. That low cycle clears the filter's accumulators.
- `filt_done_i` seen in any state other than WAIT is ignored.
- Round-robin: after every grant (completed or aborted), the search starts at `gnt+1` mod N_CH. Lowest index wins within the rotated order.
- Ack is only ever issued in RUN. A requester must hold each sample until it is acked.
- Sample counter width is $clog2(WIN+1). It never wraps, because RUN exits at WIN.

## Timing
- Reset values:
  - `ack_o` = 0, `filt_en_o` = 0, `filt_data_o` = 0.
  - `res_data_o` = 0, `res_ch_o` = 0, `res_valid_o` = 0.
  - `abort_o` = 0, `err_o` = 0.
  - State = IDLE, round-robin pointer = 0.
- Reset mid-window forces all of the above immediately. `filt_en_o` low resets the filter.
- Uninterrupted window: 1 IDLE cycle + WIN RUN cycles + DRAIN + WAIT. `res_valid_o` is high in the cycle after WAIT.
  - WIN=11: `res_valid_o` is high 14 cycles after the IDLE cycle that granted.
  - Back-to-back windows repeat every WIN+3 cycles.
- Filter done is expected in the WAIT cycle, i.e. one cycle after the last enabled filter cycle.
- `res_valid_o`, `abort_o` and `err_o` are each high for exactly one cycle, and never together.

## Configuration
- `MFS_PRIO_EN` defined: channel 0 has fixed highest priority in IDLE. Channels 1..N_CH-1 rotate round-robin among themselves, and only when `req_i[0]` = 0.
- `MFS_PRIO_EN` undefined: pure round-robin across all channels.

## Structure
- Shared package `mean_filter_pkg`:
  - state enum (IDLE/RUN/DRAIN/WAIT);
  - `SAMPLE_W` = 8;
  - default `WIN` = 11.
- One sub-module, `rr_arbiter`: N_CH request vector, rotating pointer, one-hot grant plus index, and a priority-override input for `MFS_PRIO_EN`.
- The filter is instantiated outside this block.

## Test plan
- Single channel: ch2 holds `req_i` high with samples 10..20. Expect 11 acks, `filt_en_o` high for 11 cycles, and `res_ch_o` = 2 with `res_valid_o` 14 cycles after the grant.
- All four channels requesting continuously: grants go 0,1,2,3,0. Each window is 14 cycles, with `filt_en_o` low for ≥1 cycle between windows.
- ch1 drops `req_i` after 5 acks: `abort_o` pulses, no `res_valid_o`, and the next grant goes to ch2.
- Filter model with `filt_done_i` forced low: `err_o` pulses in the cycle after WAIT, and `res_data_o` is unchanged.
- `rst_n` asserted at sample 6 of a window: all outputs go to 0 immediately. After release, the first grant starts again from ch0.
- With `MFS_PRIO_EN`, ch0 and ch3 requesting: ch0 wins every IDLE while it requests; ch3 is granted only after ch0 drops.

Source files
------------

// File: rtl/mean_filter_pkg.sv
// Shared types and constants for the mean-filter scheduler slice.
package mean_filter_pkg;
  localparam int SAMPLE_W = 8;
  localparam int WIN_DEF  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    WAIT  = 2'd3
  } state_e;
endpackage

// File: rtl/mean_filter_sched_rr_arbiter.sv
// Rotating-priority arbiter: lowest index wins in the order starting at ptr_i.
// prio_i lifts channel 0 above the rotation and removes it from the rotation.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N),
  localparam int SW = IW + 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          prio_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [N-1:0]  cand_s;
  logic [SW-1:0] sum_s;
  logic [IW-1:0] pos_s;

  // Pick the first requester in rotated order.
  always_comb begin
    cand_s = req_i;
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    sum_s  = '0;
    pos_s  = '0;
    if (prio_i && req_i[0]) begin
      gnt_o[0] = 1'b1;
      any_o    = 1'b1;
    end else begin
      if (prio_i) begin
        cand_s[0] = 1'b0;
      end else begin
        cand_s = req_i;
      end
      for (int i = 0; i < N; i++) begin
        sum_s = {1'b0, ptr_i} + SW'(i);
        if (sum_s >= SW'(N)) begin
          sum_s = sum_s - SW'(N);
        end else begin
          sum_s = sum_s;
        end
        pos_s = sum_s[IW-1:0];
        if (!any_o && cand_s[pos_s]) begin
          gnt_o[pos_s] = 1'b1;
          idx_o        = pos_s;
          any_o        = 1'b1;
        end else begin
          any_o = any_o;
        end
      end
    end
  end
endmodule

// File: rtl/mean_filter_sched.sv
// Round-robin scheduler sharing one trimmed-mean filter among N_CH requesters.
// Define MFS_PRIO_EN to give channel 0 fixed priority over the rotation.
module mean_filter_sched
  import mean_filter_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int WIN  = WIN_DEF,
  localparam int CW  = $clog2(N_CH),
  localparam int NW  = $clog2(WIN + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          req_i,
  input  logic [SAMPLE_W*N_CH-1:0] data_i,
  output logic [N_CH-1:0]          ack_o,
  output logic                     filt_en_o,
  output logic [SAMPLE_W-1:0]      filt_data_o,
  input  logic [SAMPLE_W-1:0]      filt_data_i,
  input  logic                     filt_done_i,
  output logic [SAMPLE_W-1:0]      res_data_o,
  output logic [CW-1:0]            res_ch_o,
  output logic                     res_valid_o,
  output logic                     abort_o,
  output logic                     err_o
);
  state_e              state_q, state_d;
  logic [CW-1:0]       gnt_q, gnt_d, ptr_q, ptr_d;
  logic [N_CH-1:0]     gnt_oh_q, gnt_oh_d;
  logic [NW-1:0]       cnt_q, cnt_d;
  logic                filt_en_q, filt_en_d;
  logic [SAMPLE_W-1:0] filt_data_q, filt_data_d;
  logic [SAMPLE_W-1:0] res_data_q, res_data_d;
  logic [CW-1:0]       res_ch_q, res_ch_d;
  logic                res_valid_q, res_valid_d, abort_q, abort_d, err_q, err_d;

  logic [N_CH-1:0]     arb_gnt_s;
  logic [CW-1:0]       arb_idx_s;
  logic                arb_any_s, prio_s, sel_req_s;
  logic [SAMPLE_W-1:0] sel_data_s;

`ifdef MFS_PRIO_EN
  assign prio_s = 1'b1;
`else
  assign prio_s = 1'b0;
`endif

  rr_arbiter #(.N(N_CH)) u_arb (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .prio_i (prio_s),
    .gnt_o  (arb_gnt_s),
    .idx_o  (arb_idx_s),
    .any_o  (arb_any_s)
  );

  assign sel_req_s = |(req_i & gnt_oh_q);
  assign ack_o     = (state_q == RUN) ? (req_i & gnt_oh_q) : '0;

  // Sample slice of the granted channel.
  always_comb begin
    sel_data_s = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (gnt_q == CW'(c)) begin
        sel_data_s = data_i[c*SAMPLE_W +: SAMPLE_W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Next-state and output logic; strobes default low every cycle.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_oh_d    = gnt_oh_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    filt_en_d   = filt_en_q;
    filt_data_d = filt_data_q;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    res_valid_d = 1'b0;
    abort_d     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        filt_en_d = 1'b0;
        if (arb_any_s) begin
          gnt_d    = arb_idx_s;
          gnt_oh_d = arb_gnt_s;
          ptr_d    = (arb_idx_s == CW'(N_CH - 1)) ? '0 : arb_idx_s + CW'(1);
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (sel_req_s) begin
          filt_en_d   = 1'b1;
          filt_data_d = sel_data_s;
          cnt_d       = cnt_q + NW'(1);
          state_d     = (cnt_q == NW'(WIN - 1)) ? DRAIN : RUN;
        end else begin
          // Requester gave up mid-window; the low enable flushes the filter.
          filt_en_d = 1'b0;
          abort_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      DRAIN: begin
        filt_en_d = 1'b0;
        state_d   = WAIT;
      end
      WAIT: begin
        filt_en_d = 1'b0;
        if (filt_done_i) begin
          res_data_d  = filt_data_i;
          res_ch_d    = gnt_q;
          res_valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        filt_en_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_oh_q    <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      filt_en_q   <= 1'b0;
      filt_data_q <= '0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      res_valid_q <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_oh_q    <= gnt_oh_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      filt_en_q   <= filt_en_d;
      filt_data_q <= filt_data_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      res_valid_q <= res_valid_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
    end
  end

  assign filt_en_o   = filt_en_q;
  assign filt_data_o = filt_data_q;
  assign res_data_o  = res_data_q;
  assign res_ch_o    = res_ch_q;
  assign res_valid_o = res_valid_q;
  assign abort_o     = abort_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_mean_filter_sched.sv
// Scoreboard bench for mean_filter_sched: job-level round-robin model plus a
// behavioural trimmed-mean filter; honours MFS_PRIO_EN in the model.
module tb_mean_filter_sched;
  localparam int N  = 4;
  localparam int W  = 11;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_i = '0;
  logic [8*N-1:0] data_i = '0;
  logic [N-1:0]   ack_o;
  logic           filt_en_o;
  logic [7:0]     filt_data_o;
  logic [7:0]     filt_data_i = 8'h00;
  logic           filt_done_i = 1'b0;
  logic [7:0]     res_data_o;
  logic [CW-1:0]  res_ch_o;
  logic           res_valid_o, abort_o, err_o;

  mean_filter_sched #(.N_CH(N), .WIN(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .data_i(data_i), .ack_o(ack_o),
    .filt_en_o(filt_en_o), .filt_data_o(filt_data_o), .filt_data_i(filt_data_i),
    .filt_done_i(filt_done_i), .res_data_o(res_data_o), .res_ch_o(res_ch_o),
    .res_valid_o(res_valid_o), .abort_o(abort_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int ch; int data; } ev_t;  // kind: 0 result, 1 abort, 2 error
  ev_t sb_q[$];
  int  chan_q[N][$];   // per-channel sample stream; -1 = drop req until abort
  int  job_kind[N][$];
  int  job_res[N][$];
  int  n_vec = 0, n_bad = 0, cyc = 0, model_ptr = 0, last_res = 0, last_len = 0;
  int  ack_cnt[N], fa_cyc[N];
  int  rv_cyc[$];
  logic [N-1:0] ack_cap = '0;

  function automatic int tmean(int s[$]);
    int sum, mn, mx;
    sum = 0; mn = 1000; mx = -1;
    foreach (s[i]) begin
      sum += s[i];
      if (s[i] < mn) mn = s[i];
      if (s[i] > mx) mx = s[i];
    end
    return (sum - mn - mx) / (s.size() - 2);
  endfunction

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue one window for channel c: kind 0 complete, 1 abort after k, 2 filter silent.
  task automatic add_job(int c, int kind, int k, int base);
    int s[$];
    int n;
    n = (kind == 1) ? k : W;
    for (int i = 0; i < n; i++) s.push_back(base >= 0 ? base + i : int'($urandom_range(0, 237)));
    if (kind == 2) s[0] = 238;
    foreach (s[i]) chan_q[c].push_back(s[i]);
    if (kind == 1) chan_q[c].push_back(-1);
    job_kind[c].push_back(kind);
    job_res[c].push_back(kind == 0 ? tmean(s) : 0);
  endtask

  function automatic int pick(int p);
    int c;
`ifdef MFS_PRIO_EN
    if (job_kind[0].size() > 0) return 0;
`endif
    for (int i = 0; i < N; i++) begin
      c = (p + i) % N;
`ifdef MFS_PRIO_EN
      if (c != 0 && job_kind[c].size() > 0) return c;
`else
      if (job_kind[c].size() > 0) return c;
`endif
    end
    return -1;
  endfunction

  // Round-robin over pending jobs gives the order of expected events.
  task automatic schedule();
    int c;
    ev_t e;
    c = pick(model_ptr);
    while (c >= 0) begin
      e.kind = job_kind[c].pop_front();
      e.data = job_res[c].pop_front();
      e.ch = c;
      sb_q.push_back(e);
      model_ptr = (c + 1) % N;
      c = pick(model_ptr);
    end
  endtask

  function automatic bit busy();
    for (int c = 0; c < N; c++) if (chan_q[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain();
    int t;
    t = 0;
    while ((sb_q.size() > 0 || busy()) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("drain_events_left", sb_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ack_cap <= ack_o;
  end

  // Requesters: hold each sample until acked; drop req at an abort marker.
  initial begin : drv
    forever begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (rst_n && ack_cap[c] && chan_q[c].size() > 0 && chan_q[c][0] >= 0) begin
          void'(chan_q[c].pop_front());
          ack_cnt[c]++;
          if (ack_cnt[c] == 1) fa_cyc[c] = cyc - 1;
        end
        if (rst_n && abort_o && chan_q[c].size() > 0 && chan_q[c][0] < 0)
          void'(chan_q[c].pop_front());
        req_i[c] = (chan_q[c].size() > 0 && chan_q[c][0] >= 0);
        data_i[8*c +: 8] = req_i[c] ? 8'(chan_q[c][0]) : 8'h00;
      end
    end
  end

  // Filter model: collects enabled samples; answers in the first low-enable cycle.
  initial begin : filt
    int  fs[$];
    logic en_prev;
    en_prev = 1'b0;
    forever begin
      @(negedge clk);
      filt_done_i = 1'b0;
      filt_data_i = 8'h00;
      if (!rst_n) begin
        fs.delete();
        en_prev = 1'b0;
      end else if (filt_en_o) begin
        check("en_window_len", int'(fs.size() < W), 1);
        fs.push_back(int'(filt_data_o));
        if ($urandom_range(0, 7) == 0) begin
          filt_done_i = 1'b1;   // stray done outside WAIT must be ignored
          filt_data_i = 8'($urandom);
        end
        en_prev = 1'b1;
      end else begin
        if (en_prev) begin
          last_len = fs.size();
          if (fs.size() == W && fs[0] != 238) begin
            filt_done_i = 1'b1;
            filt_data_i = 8'(tmean(fs));
          end
          fs.delete();
        end
        en_prev = 1'b0;
      end
    end
  end

  // Monitor: pop and compare on every strobe.
  initial begin : mon
    ev_t e;
    int  kind;
    forever begin
      @(negedge clk);
      if (rst_n && (res_valid_o || abort_o || err_o)) begin
        check("strobe_exclusive", int'(res_valid_o) + int'(abort_o) + int'(err_o), 1);
        kind = res_valid_o ? 0 : (abort_o ? 1 : 2);
        if (sb_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
        end else begin
          e = sb_q.pop_front();
          check("event_kind", kind, e.kind);
          if (kind == 0) begin
            rv_cyc.push_back(cyc);
            check("res_ch", int'(res_ch_o), e.ch);
            check("res_data", int'(res_data_o), e.data);
            last_res = e.data;
          end else if (kind == 2) begin
            check("err_res_hold", int'(res_data_o), last_res);
          end
        end
      end
    end
  end

  task automatic check_zero(string tag);
    check({tag, "_ack"}, int'(ack_o), 0);
    check({tag, "_en"}, int'(filt_en_o), 0);
    check({tag, "_fdata"}, int'(filt_data_o), 0);
    check({tag, "_rdata"}, int'(res_data_o), 0);
    check({tag, "_rch"}, int'(res_ch_o), 0);
    check({tag, "_strobes"}, int'({res_valid_o, abort_o, err_o}), 0);
  endtask

  initial begin : wdog
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nj, r, t;
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // All four requesting: back-to-back windows every W+3 cycles.
    rv_cyc.delete();
    add_job(0, 0, 0, -1); add_job(0, 0, 0, -1);
    add_job(1, 0, 0, -1); add_job(2, 0, 0, -1); add_job(3, 0, 0, -1);
    schedule(); drain();
    check("b2b_count", rv_cyc.size(), 5);
    for (int i = 1; i < rv_cyc.size(); i++) check("b2b_period", rv_cyc[i] - rv_cyc[i-1], W + 3);

    // Single channel 2, samples 10..20.
    for (int c = 0; c < N; c++) ack_cnt[c] = 0;
    rv_cyc.delete();
    add_job(2, 0, 0, 10);
    schedule(); drain();
    check("single_acks", ack_cnt[2], W);
    check("single_en_len", last_len, W);
    check("single_latency", rv_cyc.size() > 0 ? rv_cyc[0] - fa_cyc[2] : -1, W + 2);
    check("single_value", int'(res_data_o), 15);

    // Abort after 5 acks on ch1, then ch2 completes; then a silent filter.
    add_job(1, 1, 5, -1); add_job(2, 0, 0, -1);
    schedule(); drain();
    add_job(0, 0, 0, -1); add_job(3, 2, 0, -1);
    schedule(); drain();

    // Randomised batches.
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < N; c++) begin
        nj = $urandom_range(0, 2);
        for (int j = 0; j < nj; j++) begin
          r = $urandom_range(0, 9);
          if (r < 6) add_job(c, 0, 0, -1);
          else if (r < 8) add_job(c, 1, $urandom_range(1, W - 1), -1);
          else add_job(c, 2, 0, -1);
        end
      end
      schedule(); drain();
    end

    // Reset in the middle of a window.
    for (int c = 0; c < N; c++) ack_cnt[c] = 0;
    add_job(0, 0, 0, -1);
    schedule();
    t = 0;
    while (ack_cnt[0] < 6 && t < 200) begin @(negedge clk); t++; end
    check("midreset_reach", int'(ack_cnt[0] >= 6), 1);
    rst_n = 1'b0;
    #1 check_zero("midreset");
    sb_q.delete();
    for (int c = 0; c < N; c++) chan_q[c].delete();
    model_ptr = 0;
    last_res = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    add_job(0, 0, 0, -1); add_job(3, 0, 0, -1);
    schedule(); drain();

    // ch0 and ch3 contend; priority build keeps ch0 ahead.
    add_job(0, 0, 0, -1); add_job(0, 0, 0, -1); add_job(3, 0, 0, -1);
    schedule(); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
